eq_request_scheduler: RTL and testbench

//  Initiator/controller for the shared altitude/battery equation datapath. Accepts equation

---
 rtl/eq_request_scheduler_if.sv | 59 +++++
 rtl/eq_request_scheduler.sv | 250 +++++++++++++++++++++++++
 tb/tb_eq_request_scheduler.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/eq_request_scheduler_if.sv
// ---------------------------------------------------------------------------
// eq_sched_if
// Bundles the three handshake/bus groups of the equation request scheduler:
//   request port  : req_valid/req_ready plus req_sel, req_a/b/c, req_tag
//   datapath port : dp_sel_eq, dp_x1/dp_x2 (altitude), dp_v/dp_t/dp_c (battery),
//                   dp_result_a/dp_result_b returned by the datapath
//   response port : rsp_valid/rsp_ready plus rsp_sel, rsp_tag, rsp_data
// Modports:
//   master - the scheduler itself (drives req_ready, dp_*, rsp_* except rsp_ready)
//   slave  - the environment: front-end, datapath and response consumer
// TAG_W must match the TAG_W of the scheduler instance it is connected to.
// ---------------------------------------------------------------------------
interface eq_sched_if #(
  parameter int TAG_W = 4
);
  // request port
  logic             req_valid;
  logic             req_ready;
  logic             req_sel;
  logic [7:0]       req_a;
  logic [7:0]       req_b;
  logic [7:0]       req_c;
  logic [TAG_W-1:0] req_tag;

  // datapath port
  logic             dp_sel_eq;
  logic [7:0]       dp_x1;
  logic [7:0]       dp_x2;
  logic [7:0]       dp_v;
  logic [7:0]       dp_t;
  logic [7:0]       dp_c;
  logic [15:0]      dp_result_a;
  logic [15:0]      dp_result_b;

  // response port
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_sel;
  logic [TAG_W-1:0] rsp_tag;
  logic [15:0]      rsp_data;

  modport master (
    input  req_valid, req_sel, req_a, req_b, req_c, req_tag,
    output req_ready,
    output dp_sel_eq, dp_x1, dp_x2, dp_v, dp_t, dp_c,
    input  dp_result_a, dp_result_b,
    output rsp_valid, rsp_sel, rsp_tag, rsp_data,
    input  rsp_ready
  );

  modport slave (
    output req_valid, req_sel, req_a, req_b, req_c, req_tag,
    input  req_ready,
    input  dp_sel_eq, dp_x1, dp_x2, dp_v, dp_t, dp_c,
    output dp_result_a, dp_result_b,
    input  rsp_valid, rsp_sel, rsp_tag, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/eq_request_scheduler.sv
// ---------------------------------------------------------------------------
// eq_request_scheduler
// Front-end controller for the shared altitude/battery equation datapath.
// Requests are queued in a FIFO_DEPTH-entry FIFO, issued one at a time to the
// datapath with operands held for LAT_CYCLES cycles, and the selected result
// is returned with the request's tag on the response port.
//
// Ports:
//   clk   - clock, rising edge
//   rst   - asynchronous, active-high reset
//   bus   - eq_sched_if.master: request, datapath and response groups
//   busy  - FSM not idle or FIFO not empty
//   stat_issued, stat_stall (only with EQ_SCHED_STATS_EN defined):
//           saturating counts of issued requests and of RESP cycles spent
//           waiting on rsp_ready
//
// Configuration macro: EQ_SCHED_STATS_EN (adds the statistics counters/ports).
// ---------------------------------------------------------------------------
module eq_request_scheduler #(
  parameter int FIFO_DEPTH = 4,   // power of 2, >= 2
  parameter int LAT_CYCLES = 4,   // >= 2
  parameter int TAG_W      = 4
) (
  input  logic        clk,
  input  logic        rst,
  eq_sched_if.master  bus,
  output logic        busy
`ifdef EQ_SCHED_STATS_EN
  ,
  output logic [15:0] stat_issued,
  output logic [15:0] stat_stall
`endif
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(LAT_CYCLES);
  localparam int ENTRY_W = 1 + TAG_W + 24;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  // ---------------- state ----------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;

  logic               dp_sel_q, dp_sel_d;
  logic [7:0]         dp_x1_q, dp_x1_d;
  logic [7:0]         dp_x2_q, dp_x2_d;
  logic [7:0]         dp_v_q, dp_v_d;
  logic [7:0]         dp_t_q, dp_t_d;
  logic [7:0]         dp_c_q, dp_c_d;
  logic [TAG_W-1:0]   inflight_tag_q, inflight_tag_d;

  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_sel_q, rsp_sel_d;
  logic [TAG_W-1:0]   rsp_tag_q, rsp_tag_d;
  logic [15:0]        rsp_data_q, rsp_data_d;

`ifdef EQ_SCHED_STATS_EN
  logic [15:0]        issued_q, issued_d;
  logic [15:0]        stall_q, stall_d;
`endif

  // ---------------- FIFO storage ----------------
  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0] push_word;
  logic [ENTRY_W-1:0] pop_word;
  logic               push;
  logic               pop;

  logic               pop_sel;
  logic [TAG_W-1:0]   pop_tag;
  logic [7:0]         pop_a;
  logic [7:0]         pop_b;
  logic [7:0]         pop_c;

  assign push_word = {bus.req_sel, bus.req_tag, bus.req_a, bus.req_b, bus.req_c};
  assign pop_word  = mem[rd_ptr_q];
  assign pop_sel   = pop_word[ENTRY_W-1];
  assign pop_tag   = pop_word[24 +: TAG_W];
  assign pop_a     = pop_word[16 +: 8];
  assign pop_b     = pop_word[8 +: 8];
  assign pop_c     = pop_word[0 +: 8];

  // No pop-bypass: a full FIFO refuses the request even if the FSM pops this cycle.
  assign push = bus.req_valid && (count_q != FULL_CNT);
  assign pop  = (state_q == S_IDLE) && (count_q != '0);

  // Storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    dp_sel_d       = dp_sel_q;
    dp_x1_d        = dp_x1_q;
    dp_x2_d        = dp_x2_q;
    dp_v_d         = dp_v_q;
    dp_t_d         = dp_t_q;
    dp_c_d         = dp_c_q;
    inflight_tag_d = inflight_tag_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_sel_d      = rsp_sel_q;
    rsp_tag_d      = rsp_tag_q;
    rsp_data_d     = rsp_data_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          rd_ptr_d       = rd_ptr_q + PTR_W'(1);
          state_d        = S_ISSUE;
          cnt_d          = CNT_W'(LAT_CYCLES - 1);
          dp_sel_d       = pop_sel;
          inflight_tag_d = pop_tag;
          // Operands of the unselected equation are forced to zero.
          dp_x1_d        = pop_sel ? 8'd0  : pop_a;
          dp_x2_d        = pop_sel ? 8'd0  : pop_b;
          dp_v_d         = pop_sel ? pop_a : 8'd0;
          dp_t_d         = pop_sel ? pop_b : 8'd0;
          dp_c_d         = pop_sel ? pop_c : 8'd0;
        end
      end
      S_ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d  = dp_sel_q ? bus.dp_result_b : bus.dp_result_a;
          rsp_sel_d   = dp_sel_q;
          rsp_tag_d   = inflight_tag_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
          // dp_sel_eq deliberately keeps its value to avoid a spurious toggle.
          dp_x1_d     = 8'd0;
          dp_x2_d     = 8'd0;
          dp_v_d      = 8'd0;
          dp_t_d      = 8'd0;
          dp_c_d      = 8'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef EQ_SCHED_STATS_EN
  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (pop && (issued_q != 16'hFFFF)) begin
      issued_d = issued_q + 16'd1;
    end
    if ((state_q == S_RESP) && !bus.rsp_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end
`endif

  // ---------------- registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      dp_sel_q       <= 1'b0;
      dp_x1_q        <= 8'd0;
      dp_x2_q        <= 8'd0;
      dp_v_q         <= 8'd0;
      dp_t_q         <= 8'd0;
      dp_c_q         <= 8'd0;
      inflight_tag_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_sel_q      <= 1'b0;
      rsp_tag_q      <= '0;
      rsp_data_q     <= 16'd0;
`ifdef EQ_SCHED_STATS_EN
      issued_q       <= 16'd0;
      stall_q        <= 16'd0;
`endif
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      dp_sel_q       <= dp_sel_d;
      dp_x1_q        <= dp_x1_d;
      dp_x2_q        <= dp_x2_d;
      dp_v_q         <= dp_v_d;
      dp_t_q         <= dp_t_d;
      dp_c_q         <= dp_c_d;
      inflight_tag_q <= inflight_tag_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_sel_q      <= rsp_sel_d;
      rsp_tag_q      <= rsp_tag_d;
      rsp_data_q     <= rsp_data_d;
`ifdef EQ_SCHED_STATS_EN
      issued_q       <= issued_d;
      stall_q        <= stall_d;
`endif
    end
  end

  // ---------------- outputs ----------------
  assign bus.req_ready = (count_q != FULL_CNT);
  assign bus.dp_sel_eq = dp_sel_q;
  assign bus.dp_x1     = dp_x1_q;
  assign bus.dp_x2     = dp_x2_q;
  assign bus.dp_v      = dp_v_q;
  assign bus.dp_t      = dp_t_q;
  assign bus.dp_c      = dp_c_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sel   = rsp_sel_q;
  assign bus.rsp_tag   = rsp_tag_q;
  assign bus.rsp_data  = rsp_data_q;
  assign busy          = (state_q != S_IDLE) || (count_q != '0);

`ifdef EQ_SCHED_STATS_EN
  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_eq_request_scheduler.sv
// ---------------------------------------------------------------------------
// tb_eq_request_scheduler
// Directed + randomized bench for eq_request_scheduler (FIFO_DEPTH=4,
// LAT_CYCLES=4, TAG_W=4). A behavioural datapath drives dp_result_a/b from
// the dp_* operands; a queue of accepted requests is the reference model for
// response order, tag, equation select and result value.
// ---------------------------------------------------------------------------
module tb_eq_request_scheduler;

  localparam int TAG_W = 4;
  localparam int LAT   = 4;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic busy;
`ifdef EQ_SCHED_STATS_EN
  logic [15:0] stat_issued;
  logic [15:0] stat_stall;
`endif

  eq_sched_if #(.TAG_W(TAG_W)) bus ();

  eq_request_scheduler #(
    .FIFO_DEPTH (DEPTH),
    .LAT_CYCLES (LAT),
    .TAG_W      (TAG_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
`ifdef EQ_SCHED_STATS_EN
    ,
    .stat_issued (stat_issued),
    .stat_stall  (stat_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Equation arithmetic, 16-bit two's complement.
  function automatic logic [15:0] eq_alt(logic [7:0] a, logic [7:0] b);
    int v;
    v = 3 * int'($signed(a)) + 5 * int'($signed(b));
    return v[15:0];
  endfunction

  function automatic logic [15:0] eq_bat(logic [7:0] a, logic [7:0] b, logic [7:0] c);
    int v;
    v = int'($signed(a)) * int'($signed(b)) + int'($signed(c));
    return v[15:0];
  endfunction

  // Behavioural datapath attached to the scheduler.
  assign bus.dp_result_a = eq_alt(bus.dp_x1, bus.dp_x2);
  assign bus.dp_result_b = eq_bat(bus.dp_v, bus.dp_t, bus.dp_c);

  typedef struct {
    logic             sel;
    logic [7:0]       a;
    logic [7:0]       b;
    logic [7:0]       c;
    logic [TAG_W-1:0] tag;
  } req_t;

  req_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   acc_since_rst = 0;

  logic             hold_pend = 1'b0;
  logic [15:0]      hold_data;
  logic [TAG_W-1:0] hold_tag;
  logic             hold_sel;

  task automatic chk(string name, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // One clock cycle: update the reference model from the handshakes that
  // happen on the coming edge, then advance to 1 time unit past the edge.
  task automatic tick();
    req_t r;
    if (hold_pend) begin
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data",  32'(bus.rsp_data),  32'(hold_data));
      chk("hold_tag",   32'(bus.rsp_tag),   32'(hold_tag));
      chk("hold_sel",   32'(bus.rsp_sel),   32'(hold_sel));
    end
    hold_pend = bus.rsp_valid && !bus.rsp_ready;
    hold_data = bus.rsp_data;
    hold_tag  = bus.rsp_tag;
    hold_sel  = bus.rsp_sel;
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("rsp_tag",  32'(bus.rsp_tag),  32'(r.tag));
        chk("rsp_sel",  32'(bus.rsp_sel),  32'(r.sel));
        chk("rsp_data", 32'(bus.rsp_data),
            32'(r.sel ? eq_bat(r.a, r.b, r.c) : eq_alt(r.a, r.b)));
        $display("cyc %0d rsp tag=%0h sel=%0d data=%04h", cyc, bus.rsp_tag, bus.rsp_sel, bus.rsp_data);
      end
    end
    if (bus.req_valid && bus.req_ready) begin
      r.sel = bus.req_sel;
      r.a   = bus.req_a;
      r.b   = bus.req_b;
      r.c   = bus.req_c;
      r.tag = bus.req_tag;
      exp_q.push_back(r);
      acc_since_rst++;
      $display("cyc %0d req tag=%0h sel=%0d a=%02h b=%02h c=%02h", cyc, r.tag, r.sel, r.a, r.b, r.c);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(logic sel, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [TAG_W-1:0] tag);
    bus.req_sel = sel;
    bus.req_a   = a;
    bus.req_b   = b;
    bus.req_c   = c;
    bus.req_tag = tag;
  endtask

  task automatic set_rand_req(logic sel, logic [TAG_W-1:0] tag);
    set_req(sel, 8'($urandom), 8'($urandom), 8'($urandom), tag);
  endtask

  task automatic push_req(logic sel, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [TAG_W-1:0] tag);
    int n;
    n = 0;
    set_req(sel, a, b, c, tag);
    bus.req_valid = 1'b1;
    while (!bus.req_ready && n < 100) begin
      tick();
      n++;
    end
    chk("push_timeout", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.rsp_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 500) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  task automatic apply_reset();
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    hold_pend     = 1'b0;
    exp_q.delete();
    acc_since_rst = 0;
    #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy),          32'd0);
    chk("rst_dp",        {bus.dp_x1, bus.dp_x2, bus.dp_v, bus.dp_t}, 32'd0);
    chk("rst_dp_c_sel",  {23'd0, bus.dp_sel_eq, bus.dp_c}, 32'd0);
    chk("rst_rsp",       {11'd0, bus.rsp_sel, bus.rsp_tag, bus.rsp_data}, 32'd0);
`ifdef EQ_SCHED_STATS_EN
    chk("rst_stats",     {stat_issued, stat_stall}, 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int rise[3];
    int nrise;
    int n;
    int pushed;
    logic prev_valid;
    logic [7:0] v0, t0, c0;
`ifdef EQ_SCHED_STATS_EN
    logic [15:0] stall0;
`endif

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1'b0, 8'd0, 8'd0, 8'd0, '0);
    rst = 1'b0;
    #1;
    apply_reset();

    // 1. Altitude latency and operand hold: accepted at edge 0, rsp after edge 5.
    set_req(1'b0, 8'd2, 8'd4, 8'd9, 4'd3);
    bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_dp_x1", 32'(bus.dp_x1), 32'd2);
      chk("t1_dp_x2", 32'(bus.dp_x2), 32'd4);
      chk("t1_dp_bat", {8'd0, bus.dp_v, bus.dp_t, bus.dp_c}, 32'd0);
      chk("t1_rsp_valid", 32'(bus.rsp_valid), (k == 5) ? 32'd1 : 32'd0);
    end
    chk("t1_rsp_data", 32'(bus.rsp_data), 32'h001A);
    chk("t1_rsp_tag",  32'(bus.rsp_tag),  32'd3);
    tick();
    chk("t1_after_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t1_after_dp_x1", 32'(bus.dp_x1), 32'd0);

    // 2. Signed battery and altitude results.
    push_req(1'b1, 8'd10, 8'd3, 8'hFE, 4'd5);
    wait_rsp();
    chk("t2_bat_data", 32'(bus.rsp_data), 32'h001C);
    tick();
    push_req(1'b0, 8'hFF, 8'd1, 8'd0, 4'd6);
    wait_rsp();
    chk("t2_alt_data", 32'(bus.rsp_data), 32'h0002);
    tick();

    // 3. Backpressure for 10 cycles on a battery request.
    bus.rsp_ready = 1'b0;
    push_req(1'b1, 8'hF9, 8'd9, 8'h11, 4'd9);
    wait_rsp();
    chk("t3_bat_neg", 32'(bus.rsp_data), 32'h0000FFD2);
    v0 = bus.dp_v;
    t0 = bus.dp_t;
    c0 = bus.dp_c;
`ifdef EQ_SCHED_STATS_EN
    stall0 = stat_stall;
`endif
    repeat (10) begin
      tick();
      chk("t3_dp_hold", {8'd0, bus.dp_v, bus.dp_t, bus.dp_c}, {8'd0, v0, t0, c0});
    end
`ifdef EQ_SCHED_STATS_EN
    chk("t3_stall", 32'(stat_stall - stall0), 32'd10);
`endif
    bus.rsp_ready = 1'b1;
    tick();
    chk("t3_idle_sel_kept", 32'(bus.dp_sel_eq), 32'd1);
    chk("t3_idle_dp_zero", {8'd0, bus.dp_v, bus.dp_t, bus.dp_c}, 32'd0);
    chk("t3_idle_valid", 32'(bus.rsp_valid), 32'd0);

    // 4. Full FIFO: six back-to-back pushes with responses blocked.
    bus.rsp_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      set_rand_req(1'($urandom), 4'(i + 1));
      bus.req_valid = 1'b1;
      if (bus.req_ready) accepted++;
      tick();
    end
    bus.req_valid = 1'b0;
    chk("t4_accepted", 32'(accepted), 32'd5);
    chk("t4_req_ready", 32'(bus.req_ready), 32'd0);
    drain();

    // 5. Reset while the first of three requests is in ISSUE with cnt=1.
    for (int i = 0; i < 3; i++) begin
      set_rand_req(1'($urandom), 4'(i + 8));
      bus.req_valid = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    tick();
    apply_reset();
    repeat (8) begin
      tick();
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    push_req(1'b1, 8'hEC, 8'h05, 8'h64, 4'd12);
    wait_rsp();
    chk("t5_fresh_data", 32'(bus.rsp_data), 32'h0000);
    chk("t5_fresh_tag",  32'(bus.rsp_tag),  32'd12);
    tick();

    // 6. Mixed alt/bat/alt stream with rsp_ready held high.
    for (int i = 0; i < 3; i++) begin
      set_rand_req((i == 1) ? 1'b1 : 1'b0, 4'(i + 1));
      bus.req_valid = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    nrise = 0;
    n = 0;
    prev_valid = 1'b0;
    while (nrise < 3 && n < 60) begin
      if (bus.rsp_valid) begin
        chk("t6_sel_eq_match", 32'(bus.dp_sel_eq), 32'(bus.rsp_sel));
      end
      if (bus.rsp_valid && !prev_valid) begin
        rise[nrise] = cyc;
        nrise++;
      end
      prev_valid = bus.rsp_valid;
      tick();
      n++;
    end
    chk("t6_nrise", 32'(nrise), 32'd3);
    if (nrise == 3) begin
      chk("t6_space01", 32'(rise[1] - rise[0]), 32'(LAT + 2));
      chk("t6_space12", 32'(rise[2] - rise[1]), 32'(LAT + 2));
    end
    drain();

    // 7. Random stream with random backpressure.
    pushed = 0;
    n = 0;
    while (pushed < 30 && n < 3000) begin
      set_rand_req(1'($urandom), 4'($urandom));
      bus.req_valid = 1'($urandom);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      if (bus.req_valid && bus.req_ready) pushed++;
      tick();
      n++;
    end
    bus.req_valid = 1'b0;
    chk("t7_pushed", 32'(pushed), 32'd30);
    drain();
`ifdef EQ_SCHED_STATS_EN
    chk("t7_issued", 32'(stat_issued), 32'(acc_since_rst));
`endif
    chk("t7_req_ready", 32'(bus.req_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
